// File: rtl/rc4_prga_decrypt.sv
// RC4 pseudo-random generation stage: walks the permuted S array held in the
// shared S RAM, XORs the keystream with the ciphertext ROM and writes plaintext
// into the message RAM, flagging whether every written byte looks like text.
module rc4_prga_decrypt #(
    parameter int unsigned MSG_LEN          = 32,
    parameter int unsigned MSG_AW           = 5,
    parameter int unsigned ABORT_ON_INVALID = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic              key_valid,
    output logic [7:0]        s_mem_addr,
    output logic [7:0]        s_mem_data_in,
    input  logic [7:0]        s_mem_data_out,
    output logic              s_mem_write,
    output logic [MSG_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [MSG_AW-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic              ram_wren
);

    localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

    typedef enum logic [3:0] {
        IDLE, RD_I, RD_I_W, RD_J, RD_J_W, WR_I, WR_J,
        RD_F, RD_F_W, WR_OUT, NEXT, DONE
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        i_q, i_d, j_q, j_d;
    logic [7:0]        si_q, si_d, sj_q, sj_d;
    logic [7:0]        f_q, f_d, enc_q, enc_d;
    logic [MSG_AW-1:0] k_q, k_d;
    logic              kv_q, kv_d;

    logic [7:0]        s_addr_q, s_addr_d, s_din_q, s_din_d;
    logic              s_we_q, s_we_d;
    logic [MSG_AW-1:0] rom_addr_q, rom_addr_d, ram_addr_q, ram_addr_d;
    logic [7:0]        ram_data_q, ram_data_d;
    logic              ram_we_q, ram_we_d, done_q, done_d;

    // Lower-case letters and space are the only bytes accepted as plausible text.
    function automatic logic is_text(input logic [7:0] b);
        return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
    endfunction

    // Next-state and datapath: one swap-and-emit pass per message byte.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        si_d    = si_q;
        sj_d    = sj_q;
        f_d     = f_q;
        enc_d   = enc_q;
        kv_d    = kv_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RD_I;
                    i_d     = 8'd1;
                    j_d     = 8'd0;
                    k_d     = '0;
                    kv_d    = 1'b1;
                end
            end
            RD_I:   state_d = RD_I_W;
            RD_I_W: begin
                si_d    = s_mem_data_out;
                j_d     = j_q + s_mem_data_out;
                state_d = RD_J;
            end
            RD_J:   state_d = RD_J_W;
            RD_J_W: begin
                sj_d    = s_mem_data_out;
                state_d = WR_I;
            end
            WR_I:   state_d = WR_J;
            WR_J:   state_d = RD_F;
            RD_F:   state_d = RD_F_W;
            RD_F_W: begin
                f_d     = s_mem_data_out;
                enc_d   = rom_data;
                state_d = WR_OUT;
            end
            WR_OUT: begin
                if (!is_text(f_q ^ enc_q)) begin
                    kv_d = 1'b0;
                end
                state_d = NEXT;
            end
            NEXT: begin
                if (((ABORT_ON_INVALID != 0) && !kv_q) || (k_q == K_LAST)) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + MSG_AW'(1);
                    i_d     = i_q + 8'd1;
                    state_d = RD_I;
                end
            end
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the upcoming state so that every port is a flop.
    always_comb begin
        s_addr_d   = 8'd0;
        s_din_d    = 8'd0;
        s_we_d     = 1'b0;
        rom_addr_d = '0;
        ram_addr_d = '0;
        ram_data_d = 8'd0;
        ram_we_d   = 1'b0;
        done_d     = 1'b0;
        case (state_d)
            RD_I, RD_I_W: s_addr_d = i_d;
            RD_J, RD_J_W: s_addr_d = j_d;
            WR_I: begin
                s_addr_d = i_d;
                s_din_d  = sj_d;
                s_we_d   = 1'b1;
            end
            WR_J: begin
                s_addr_d = j_d;
                s_din_d  = si_d;
                s_we_d   = 1'b1;
            end
            RD_F, RD_F_W: begin
                s_addr_d   = si_d + sj_d;
                rom_addr_d = k_d;
            end
            WR_OUT: begin
                ram_addr_d = k_d;
                ram_data_d = f_d ^ enc_d;
                ram_we_d   = 1'b1;
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            i_q        <= 8'd0;
            j_q        <= 8'd0;
            k_q        <= '0;
            si_q       <= 8'd0;
            sj_q       <= 8'd0;
            f_q        <= 8'd0;
            enc_q      <= 8'd0;
            kv_q       <= 1'b0;
            s_addr_q   <= 8'd0;
            s_din_q    <= 8'd0;
            s_we_q     <= 1'b0;
            rom_addr_q <= '0;
            ram_addr_q <= '0;
            ram_data_q <= 8'd0;
            ram_we_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            si_q       <= si_d;
            sj_q       <= sj_d;
            f_q        <= f_d;
            enc_q      <= enc_d;
            kv_q       <= kv_d;
            s_addr_q   <= s_addr_d;
            s_din_q    <= s_din_d;
            s_we_q     <= s_we_d;
            rom_addr_q <= rom_addr_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_we_q   <= ram_we_d;
            done_q     <= done_d;
        end
    end

    assign done          = done_q;
    assign key_valid     = kv_q;
    assign s_mem_addr    = s_addr_q;
    assign s_mem_data_in = s_din_q;
    assign s_mem_write   = s_we_q;
    assign rom_addr      = rom_addr_q;
    assign ram_addr      = ram_addr_q;
    assign ram_data      = ram_data_q;
    assign ram_wren      = ram_we_q;

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Bench for rc4_prga_decrypt: four instances (MSG_LEN/abort variants) share one
// set of memory models; results are checked against a software RC4 model.
module tb_rc4_prga_decrypt;

    localparam int unsigned NDUT = 4;
    localparam int unsigned AW   = 5;

    logic clk = 1'b0;
    logic reset;
    logic [NDUT-1:0]         start, done, key_valid, s_we, ram_we;
    logic [NDUT-1:0][7:0]    s_addr, s_din, ram_din;
    logic [NDUT-1:0][AW-1:0] rom_addr, ram_addr;
    logic [7:0]              s_rd, rom_rd;
    int                      sel;

    always #5 clk = ~clk;

    // 0: len 6 abort, 1: len 9 abort, 2: len 9 no abort, 3: len 32 no abort
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        rc4_prga_decrypt #(
            .MSG_LEN((g == 0) ? 6 : ((g == 3) ? 32 : 9)),
            .MSG_AW(AW),
            .ABORT_ON_INVALID((g == 2 || g == 3) ? 0 : 1)
        ) u_dut (
            .clk(clk), .reset(reset), .start(start[g]),
            .done(done[g]), .key_valid(key_valid[g]),
            .s_mem_addr(s_addr[g]), .s_mem_data_in(s_din[g]),
            .s_mem_data_out(s_rd), .s_mem_write(s_we[g]),
            .rom_addr(rom_addr[g]), .rom_data(rom_rd),
            .ram_addr(ram_addr[g]), .ram_data(ram_din[g]), .ram_wren(ram_we[g])
        );
    end

    // Memory models, 1-cycle synchronous read, serving the selected instance.
    logic [7:0] smem [256];
    logic [7:0] s_init [256];
    logic [7:0] rom [32];
    logic [7:0] ram [32];
    logic       ld = 1'b0;
    int         s_wr_cnt = 0;
    int         ram_wr_cnt = 0;
    logic [7:0] wlog_a [$];
    logic [7:0] wlog_d [$];

    always @(posedge clk) begin
        if (ld) begin
            for (int n = 0; n < 256; n++) smem[n] <= s_init[n];
            for (int n = 0; n < 32; n++) ram[n] <= 8'h00;
        end else begin
            s_rd   <= smem[s_addr[sel]];
            rom_rd <= rom[rom_addr[sel]];
            if (s_we[sel]) begin
                smem[s_addr[sel]] <= s_din[sel];
                s_wr_cnt <= s_wr_cnt + 1;
                wlog_a.push_back(s_addr[sel]);
                wlog_d.push_back(s_din[sel]);
            end
            if (ram_we[sel]) begin
                ram[ram_addr[sel]] <= ram_din[sel];
                ram_wr_cnt <= ram_wr_cnt + 1;
            end
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Software RC4 reference.
    logic [7:0] kbuf [8];
    logic [7:0] ms [256];
    logic [7:0] exp_pt [32];
    int         exp_nw;
    logic       exp_kv;

    function automatic logic is_text(input logic [7:0] b);
        return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
    endfunction

    task automatic ksa(input int klen);
        int j = 0;
        logic [7:0] t;
        for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
        for (int n = 0; n < 256; n++) begin
            j = (j + int'(s_init[n]) + int'(kbuf[n % klen])) % 256;
            t = s_init[n]; s_init[n] = s_init[j]; s_init[j] = t;
        end
    endtask

    task automatic model_run(input int len, input logic abort);
        int i = 0;
        int j = 0;
        logic [7:0] t;
        for (int n = 0; n < 256; n++) ms[n] = s_init[n];
        exp_nw = 0;
        exp_kv = 1'b1;
        for (int k = 0; k < len; k++) begin
            i = (i + 1) % 256;
            j = (j + int'(ms[i])) % 256;
            t = ms[i]; ms[i] = ms[j]; ms[j] = t;
            exp_pt[k] = ms[(int'(ms[i]) + int'(ms[j])) % 256] ^ rom[k];
            exp_nw = k + 1;
            if (!is_text(exp_pt[k])) exp_kv = 1'b0;
            if (abort && !exp_kv) break;
        end
    endtask

    task automatic load_mem();
        ld = 1'b1;
        @(posedge clk); #1;
        ld = 1'b0;
    endtask

    // Raise start and count cycles from the sampling edge until done rises.
    task automatic run_dut(input int n, input int max_cyc, output int lat);
        sel = n;
        start[n] = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!done[n] && lat < max_cyc) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic end_run(input string tag, input int n);
        start[n] = 1'b0;
        @(posedge clk); #1;
        check_eq($sformatf("%s_done_fall", tag), 32'(done[n]), 32'd0);
    endtask

    task automatic check_vs_model(input string tag, input int n, input int lat, input int ram_base);
        int diffs = 0;
        check_eq($sformatf("%s_lat", tag), 32'(lat), 32'(exp_nw * 10));
        check_eq($sformatf("%s_kv", tag), 32'(key_valid[n]), 32'(exp_kv));
        check_eq($sformatf("%s_ram_writes", tag), 32'(ram_wr_cnt - ram_base), 32'(exp_nw));
        for (int k = 0; k < exp_nw; k++) if (ram[k] !== exp_pt[k]) diffs++;
        check_eq($sformatf("%s_pt_diffs", tag), 32'(diffs), 32'd0);
        diffs = 0;
        for (int m = 0; m < 256; m++) if (smem[m] !== ms[m]) diffs++;
        check_eq($sformatf("%s_s_diffs", tag), 32'(diffs), 32'd0);
    endtask

    logic [7:0] attack_ct [6] = '{8'h8A, 8'hEB, 8'h03, 8'hE0, 8'hD4, 8'h5F};
    logic [7:0] attack_pt [6] = '{8'h61, 8'h74, 8'h74, 8'h61, 8'h63, 8'h6B};
    logic [7:0] plain_ct [9]  = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] plain_pt [9]  = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};

    task automatic key_key();
        kbuf[0] = 8'h4B; kbuf[1] = 8'h65; kbuf[2] = 8'h79;
        ksa(3);
    endtask

    initial begin
        int lat;
        int base;
        int sbase;
        int lbase;
        int hold_cnt;
        reset = 1'b1;
        start = '0;
        sel   = 0;
        for (int k = 0; k < 32; k++) rom[k] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_kv", 32'(key_valid), 32'd0);
        check_eq("rst_we", 32'({s_we, ram_we}), 32'd0);
        check_eq("rst_saddr", 32'(s_addr), 32'd0);
        check_eq("rst_sdin", 32'(s_din), 32'd0);
        check_eq("rst_romaddr", 32'(rom_addr), 32'd0);
        check_eq("rst_ram", 32'({ram_addr, ram_din[1:0]}), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // "attack" with key "Key", abort enabled, 6 bytes
        key_key();
        for (int k = 0; k < 6; k++) rom[k] = attack_ct[k];
        load_mem();
        model_run(6, 1'b1);
        base = ram_wr_cnt;
        run_dut(0, 200, lat);
        check_eq("attack_lat", 32'(lat), 32'd60);
        check_eq("attack_kv", 32'(key_valid[0]), 32'd1);
        for (int k = 0; k < 6; k++) check_eq($sformatf("attack_pt%0d", k), 32'(ram[k]), 32'(attack_pt[k]));
        check_vs_model("attack", 0, lat, base);

        // start held high in DONE: no further writes, done stays up
        sbase = s_wr_cnt;
        base  = ram_wr_cnt;
        hold_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done[0]) hold_cnt++;
        end
        check_eq("hold_done", 32'(hold_cnt), 32'd20);
        check_eq("hold_s_writes", 32'(s_wr_cnt - sbase), 32'd0);
        check_eq("hold_ram_writes", 32'(ram_wr_cnt - base), 32'd0);
        end_run("hold", 0);

        // restart from a fresh S
        load_mem();
        base = ram_wr_cnt;
        run_dut(0, 200, lat);
        check_eq("restart_lat", 32'(lat), 32'd60);
        check_eq("restart_pt0", 32'(ram[0]), 32'h61);
        check_vs_model("restart", 0, lat, base);
        end_run("restart", 0);

        // "Plaintext", abort enabled: stops after the first byte
        key_key();
        for (int k = 0; k < 9; k++) rom[k] = plain_ct[k];
        load_mem();
        model_run(9, 1'b1);
        base = ram_wr_cnt;
        run_dut(1, 300, lat);
        check_eq("abort_lat", 32'(lat), 32'd10);
        check_eq("abort_kv", 32'(key_valid[1]), 32'd0);
        check_eq("abort_pt0", 32'(ram[0]), 32'h50);
        check_eq("abort_pt1", 32'(ram[1]), 32'h00);
        check_vs_model("abort", 1, lat, base);
        end_run("abort", 1);

        // "Plaintext", abort disabled: all nine bytes
        key_key();
        load_mem();
        model_run(9, 1'b0);
        base = ram_wr_cnt;
        run_dut(2, 300, lat);
        check_eq("noabort_lat", 32'(lat), 32'd90);
        check_eq("noabort_kv", 32'(key_valid[2]), 32'd0);
        for (int k = 0; k < 9; k++) check_eq($sformatf("noabort_pt%0d", k), 32'(ram[k]), 32'(plain_pt[k]));
        check_vs_model("noabort", 2, lat, base);
        end_run("noabort", 2);

        // identity S: first byte is the i==j self-swap at index 1
        for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
        for (int k = 0; k < 32; k++) rom[k] = 8'($urandom_range(255));
        load_mem();
        model_run(32, 1'b0);
        base  = ram_wr_cnt;
        lbase = wlog_a.size();
        run_dut(3, 600, lat);
        check_eq("ident_wr_i_addr", 32'(wlog_a[lbase]), 32'd1);
        check_eq("ident_wr_i_data", 32'(wlog_d[lbase]), 32'd1);
        check_eq("ident_wr_j_addr", 32'(wlog_a[lbase + 1]), 32'd1);
        check_eq("ident_wr_j_data", 32'(wlog_d[lbase + 1]), 32'd1);
        check_vs_model("ident", 3, lat, base);
        end_run("ident", 3);

        // reset during the third byte
        for (int k = 0; k < 5; k++) kbuf[k] = 8'($urandom_range(255));
        ksa(5);
        load_mem();
        sel = 3;
        start[3] = 1'b1;
        repeat (26) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_eq("midrst_done_kv", 32'({done[3], key_valid[3]}), 32'd0);
        check_eq("midrst_we", 32'({s_we[3], ram_we[3]}), 32'd0);
        check_eq("midrst_addr", 32'({s_addr[3], s_din[3], rom_addr[3], ram_addr[3]}), 32'd0);
        check_eq("midrst_data", 32'(ram_din[3]), 32'd0);
        start[3] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        load_mem();
        model_run(32, 1'b0);
        base = ram_wr_cnt;
        run_dut(3, 600, lat);
        check_vs_model("postrst", 3, lat, base);
        end_run("postrst", 3);

        // random keys; even trials carry text plaintext, odd trials random bytes
        for (int t = 0; t < 4; t++) begin
            int klen;
            klen = int'($urandom_range(8, 3));
            for (int k = 0; k < klen; k++) kbuf[k] = 8'($urandom_range(255));
            ksa(klen);
            for (int k = 0; k < 32; k++) rom[k] = 8'h00;
            if (t % 2 == 0) begin
                model_run(32, 1'b0);
                for (int k = 0; k < 32; k++)
                    rom[k] = exp_pt[k] ^ (($urandom_range(26) == 26) ? 8'h20 : 8'(8'h61 + $urandom_range(25)));
            end else begin
                for (int k = 0; k < 32; k++) rom[k] = 8'($urandom_range(255));
            end
            load_mem();
            model_run(32, 1'b0);
            base = ram_wr_cnt;
            run_dut(3, 600, lat);
            check_vs_model($sformatf("rand%0d", t), 3, lat, base);
            if (t % 2 == 0) check_eq($sformatf("rand%0d_text_kv", t), 32'(key_valid[3]), 32'd1);
            end_run($sformatf("rand%0d", t), 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
